// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the line-refill port arbiter
package mem_port_arbiter_pkg;

    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational I/D grant selection
module mem_arb_rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic i_ireq,
    input  logic i_dreq,
    input  gnt_t i_last_grant,
    output gnt_t o_grant
);

    // On a tie, fixed priority favours D; round-robin favours whoever did not win last.
    always_comb begin
        o_grant = GNT_I;
        if (i_ireq && i_dreq) begin
            o_grant = (!RR_EN || i_last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (i_dreq) begin
            o_grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one line-refill memory port between ICache and DCache
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = LINE_W_DEF,
    parameter bit RR_EN     = 1'b1,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ready_o,
    output logic [LINE_W-1:0] i_data_o,
    input  logic              d_valid_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic [LINE_W-1:0] d_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_valid_req_o,
    output logic              mem_we_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              timeout_err_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    arb_state_t            r_state;
    gnt_t                  r_gnt;
    gnt_t                  r_last_grant;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic                  r_i_ready;
    logic                  r_d_ready;
    logic [LINE_W-1:0]     r_i_data;
    logic [LINE_W-1:0]     r_d_data;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_mem_valid;
    logic                  r_mem_we;
    logic [LINE_W-1:0]     r_mem_wdata;
    logic                  r_timeout_err;
    gnt_t                  w_pick;

    mem_arb_rr_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .i_ireq      (i_valid_req_i),
        .i_dreq      (d_valid_req_i),
        .i_last_grant(r_last_grant),
        .o_grant     (w_pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_gnt         <= GNT_I;
            r_last_grant  <= GNT_D;
            r_cnt         <= '0;
            r_i_ready     <= 1'b0;
            r_d_ready     <= 1'b0;
            r_i_data      <= '0;
            r_d_data      <= '0;
            r_mem_addr    <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (i_valid_req_i || d_valid_req_i) begin
                        r_gnt        <= w_pick;
                        r_last_grant <= w_pick;
                        if (w_pick == GNT_D) begin
                            r_mem_addr  <= d_addr_i;
                            r_mem_we    <= d_we_i;
                            r_mem_wdata <= d_wdata_i;
                        end else begin
                            r_mem_addr  <= i_addr_i;
                            r_mem_we    <= 1'b0;
                            r_mem_wdata <= '0;
                        end
                        r_mem_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    // A response on the last counted cycle still beats the timeout.
                    if (mem_ready_i) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= ARB_DONE;
                        if (r_gnt == GNT_D) begin
                            r_d_ready <= 1'b1;
                            if (!r_mem_we) begin
                                r_d_data <= mem_data_i;
                            end
                        end else begin
                            r_i_ready <= 1'b1;
                            r_i_data  <= mem_data_i;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        r_mem_valid   <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ARB_DONE;
                        if (r_gnt == GNT_D) begin
                            r_d_ready <= 1'b1;
                            r_d_data  <= '0;
                        end else begin
                            r_i_ready <= 1'b1;
                            r_i_data  <= '0;
                        end
                    end
                end
                ARB_DONE: begin
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign i_ready_o       = r_i_ready;
    assign i_data_o        = r_i_data;
    assign d_ready_o       = r_d_ready;
    assign d_data_o        = r_d_data;
    assign mem_addr_o      = r_mem_addr;
    assign mem_valid_req_o = r_mem_valid;
    assign mem_we_o        = r_mem_we;
    assign mem_wdata_o     = r_mem_wdata;
    assign timeout_err_o   = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
    } mexp_t;

    typedef struct packed {
        logic         port;
        logic [127:0] data;
        logic         tmo;
    } rexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv, dv, dwe, mrdy;
    logic [31:0]  ia, da;
    logic [127:0] dwd, mdata;
    logic         i_rdy, d_rdy, mv, mwe, terr;
    logic [127:0] i_dat, d_dat, mwd;
    logic [31:0]  maddr;

    logic         b_iv, b_dv, b_dwe, b_mrdy;
    logic [31:0]  b_ia, b_da;
    logic [127:0] b_dwd, b_mdata;
    logic         b_i_rdy, b_d_rdy, b_mv, b_mwe, b_terr;
    logic [127:0] b_i_dat, b_d_dat, b_mwd;
    logic [31:0]  b_maddr;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .RR_EN(1'b1), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid_req_i(iv), .i_addr_i(ia), .i_ready_o(i_rdy), .i_data_o(i_dat),
        .d_valid_req_i(dv), .d_addr_i(da), .d_we_i(dwe), .d_wdata_i(dwd),
        .d_ready_o(d_rdy), .d_data_o(d_dat),
        .mem_addr_o(maddr), .mem_valid_req_o(mv), .mem_we_o(mwe), .mem_wdata_o(mwd),
        .mem_ready_i(mrdy), .mem_data_i(mdata), .timeout_err_o(terr)
    );

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .RR_EN(1'b0), .TIMEOUT_W(4)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_valid_req_i(b_iv), .i_addr_i(b_ia), .i_ready_o(b_i_rdy), .i_data_o(b_i_dat),
        .d_valid_req_i(b_dv), .d_addr_i(b_da), .d_we_i(b_dwe), .d_wdata_i(b_dwd),
        .d_ready_o(b_d_rdy), .d_data_o(b_d_dat),
        .mem_addr_o(b_maddr), .mem_valid_req_o(b_mv), .mem_we_o(b_mwe), .mem_wdata_o(b_mwd),
        .mem_ready_i(b_mrdy), .mem_data_i(b_mdata), .timeout_err_o(b_terr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] line(input logic [31:0] a);
        return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, ~a, a};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mexp_t        q_mem[$];
    rexp_t        q_rsp[$];
    logic [127:0] last_d;
    int           lat = 3;
    int           mrdy_cyc = 0;
    int           busy_start = 0;
    int           req_cyc = 0;
    bit           stray = 0;

    // Memory model for the round-robin instance: answers on BUSY cycle index 'lat' (-1 = never).
    initial begin : responder
        int rcnt;
        rcnt  = 0;
        mrdy  = 1'b0;
        mdata = '0;
        forever begin
            @(negedge clk);
            mrdy = 1'b0;
            if (!rst_n || !mv) begin
                rcnt = 0;
            end else begin
                if (lat >= 0 && rcnt == lat) begin
                    mrdy     = 1'b1;
                    mdata    = line(maddr);
                    mrdy_cyc = cyc;
                end
                rcnt++;
            end
            if (stray) mrdy = 1'b1;
        end
    end

    initial begin : responder_fp
        b_mrdy  = 1'b0;
        b_mdata = '0;
        forever begin
            @(negedge clk);
            b_mrdy  = b_mv;
            b_mdata = line(b_maddr);
        end
    end

    initial begin : monitor
        bit    prev_v;
        mexp_t m;
        rexp_t r;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (mv && !prev_v) begin
                    busy_start = cyc;
                    if (q_mem.size() == 0) begin
                        chk("mem_unexpected", 1'b1, 1'b0);
                    end else begin
                        m = q_mem.pop_front();
                        chk("mem_addr", maddr, m.addr);
                        chk("mem_we", mwe, m.we);
                        if (m.we) chk("mem_wdata", mwd, m.wdata);
                    end
                end
                prev_v = mv;
                if (i_rdy || d_rdy) begin
                    if (q_rsp.size() == 0) begin
                        chk("rsp_unexpected", {i_rdy, d_rdy}, 2'b00);
                    end else begin
                        r = q_rsp.pop_front();
                        chk("rsp_port", {i_rdy, d_rdy}, r.port ? 2'b01 : 2'b10);
                        chk("rsp_data", r.port ? d_dat : i_dat, r.data);
                        chk("rsp_lat", cyc, r.tmo ? busy_start + 16 : mrdy_cyc + 1);
                        chk("rsp_memv_low", mv, 1'b0);
                    end
                end
            end
        end
    end

    task automatic exp_txn(input logic port, input logic [31:0] a, input logic we,
                           input logic [127:0] wd, input logic tmo);
        mexp_t m;
        rexp_t r;
        m.addr  = a;
        m.we    = port & we;
        m.wdata = wd;
        r.port  = port;
        r.tmo   = tmo;
        if (tmo) r.data = '0;
        else if (port && we) r.data = last_d;
        else r.data = line(a);
        if (port) last_d = r.data;
        q_mem.push_back(m);
        q_rsp.push_back(r);
    endtask

    task automatic do_i(input logic [31:0] a);
        bit got;
        got = 1'b0;
        @(negedge clk);
        iv = 1'b1; ia = a; req_cyc = cyc;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (i_rdy) got = 1'b1;
        end
        iv = 1'b0;
        chk("i_done", got, 1'b1);
    endtask

    task automatic do_d(input logic [31:0] a, input logic we, input logic [127:0] wd);
        bit got;
        got = 1'b0;
        @(negedge clk);
        dv = 1'b1; da = a; dwe = we; dwd = wd;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (d_rdy) got = 1'b1;
        end
        dv = 1'b0;
        chk("d_done", got, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        iv = 1'b0; dv = 1'b0; b_iv = 1'b0; b_dv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_d = '0;
        q_mem.delete();
        q_rsp.delete();
    endtask

    task automatic wait_fp(output bit got);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (b_i_rdy || b_d_rdy) got = 1'b1;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog act=still_running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] wd;
        logic [31:0]  a;
        bit           got;
        rst_n = 1'b0;
        iv = 0; dv = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
        b_iv = 0; b_dv = 0; b_dwe = 0; b_ia = '0; b_da = '0; b_dwd = '0;
        last_d = '0;
        do_reset();

        chk("rst_ctrl", {mv, mwe, i_rdy, d_rdy, terr}, 5'b0);
        chk("rst_addr", maddr, 32'h0);
        chk("rst_wdata", mwd, 128'h0);
        chk("rst_idata", i_dat, 128'h0);
        chk("rst_ddata", d_dat, 128'h0);

        lat = 3;
        exp_txn(1'b0, 32'h0000_0040, 1'b0, '0, 1'b0);
        do_i(32'h0000_0040);
        chk("req_to_memv", busy_start, req_cyc + 1);

        // Ties after reset: I, D, then I again; after a lone I grant a tie goes to D.
        do_reset();
        lat = 1;
        exp_txn(1'b0, 32'h200, 1'b0, '0, 1'b0);
        exp_txn(1'b1, 32'h300, 1'b0, '0, 1'b0);
        fork
            do_i(32'h200);
            do_d(32'h300, 1'b0, '0);
        join
        exp_txn(1'b0, 32'h240, 1'b0, '0, 1'b0);
        exp_txn(1'b1, 32'h340, 1'b0, '0, 1'b0);
        fork
            do_i(32'h240);
            do_d(32'h340, 1'b0, '0);
        join
        lat = 0;
        exp_txn(1'b0, 32'h80, 1'b0, '0, 1'b0);
        do_i(32'h80);
        exp_txn(1'b1, 32'h380, 1'b0, '0, 1'b0);
        exp_txn(1'b0, 32'h280, 1'b0, '0, 1'b0);
        fork
            do_i(32'h280);
            do_d(32'h380, 1'b0, '0);
        join

        lat = 2;
        wd = {16{8'hA5}};
        exp_txn(1'b1, 32'h100, 1'b1, wd, 1'b0);
        do_d(32'h100, 1'b1, wd);

        @(negedge clk);
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ready_idle", {i_rdy, d_rdy, mv, terr}, 4'b0);
        end

        lat = 15;
        exp_txn(1'b0, 32'h400, 1'b0, '0, 1'b0);
        do_i(32'h400);
        chk("late_ready_no_err", terr, 1'b0);

        lat = -1;
        exp_txn(1'b0, 32'h440, 1'b0, '0, 1'b1);
        do_i(32'h440);
        chk("timeout_err_set", terr, 1'b1);
        lat = 1;
        exp_txn(1'b1, 32'h140, 1'b0, '0, 1'b0);
        do_d(32'h140, 1'b0, '0);
        chk("timeout_err_sticky", terr, 1'b1);

        lat = -1;
        exp_txn(1'b0, 32'h500, 1'b0, '0, 1'b0);
        @(negedge clk);
        iv = 1'b1; ia = 32'h500;
        repeat (4) @(negedge clk);
        chk("mid_busy", mv, 1'b1);
        rst_n = 1'b0;
        iv = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", {mv, mwe, i_rdy, d_rdy, terr}, 5'b0);
        chk("rst_mid_addr", maddr, 32'h0);
        chk("rst_mid_data", {i_dat, d_dat}, 256'h0);
        rst_n = 1'b1;
        q_rsp.delete();
        last_d = '0;
        lat = 2;
        exp_txn(1'b0, 32'h600, 1'b0, '0, 1'b0);
        do_i(32'h600);

        // Fixed-priority instance: D keeps winning while it keeps requesting.
        do_reset();
        @(negedge clk);
        b_iv = 1'b1; b_ia = 32'h700;
        b_dv = 1'b1; b_da = 32'h800;
        for (int k = 0; k < 3; k++) begin
            a = 32'h800 + 32'(k) * 32'h40;
            wait_fp(got);
            chk("fp_got", got, 1'b1);
            chk("fp_d_wins", {b_i_rdy, b_d_rdy}, 2'b01);
            chk("fp_d_data", b_d_dat, line(a));
            b_da = a + 32'h40;
            if (k == 2) b_dv = 1'b0;
        end
        wait_fp(got);
        chk("fp_got_i", got, 1'b1);
        chk("fp_i_served", {b_i_rdy, b_d_rdy}, 2'b10);
        chk("fp_i_data", b_i_dat, line(32'h700));
        b_iv = 1'b0;

        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", q_rsp.size(), 0);
        chk("mem_queue_drained", q_mem.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
